mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single tagged memory port between the instruction cache and the data cache.
- Grants at most one request per cycle. Default policy is dcache priority, with a starvation guard for the icache.
- Records which requester owns each outstanding load tag, so returning data is routed to the correct cache.
- Sits between icache/dcache and the `mem` model; both caches keep their existing memory-side interface unchanged.

Parameters:
- TAG_W, 4, memory tag width; tag 0 means "no tag / rejected".
- STARVE_LIMIT, 4, consecutive denied icache cycles after which the icache wins arbitration.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset
- proc2Imem_command  in  2  icache command (0 NONE, 1 LOAD, 2 STORE)
- proc2Imem_addr  in  XLEN  icache address
- Imem2proc_response  out  TAG_W  accept tag to icache; 0 = not accepted
- Imem2proc_data  out  64  returned data to icache
- Imem2proc_tag  out  TAG_W  returning tag to icache; 0 = none
- proc2Dmem_command  in  2  dcache command
- proc2Dmem_addr  in  XLEN  dcache address
- proc2Dmem_data  in  64  dcache store data
- Dmem2proc_response  out  TAG_W  accept tag to dcache
- Dmem2proc_data  out  64  returned data to dcache
- Dmem2proc_tag  out  TAG_W  returning tag to dcache
- proc2mem_command  out  2  to memory
- proc2mem_addr  out  XLEN  to memory
- proc2mem_data  out  64  to memory
- mem2proc_response  in  TAG_W  memory accept tag
- mem2proc_data  in  64  memory return data
- mem2proc_tag  in  TAG_W  memory return tag
- stray_tag  out  1  pulse: return tag had no recorded owner

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is `clock`.

Arbitration (combinational, same cycle):
- A requester is active when its command != NONE.
- If only one requester is active, it is granted.
- If both are active, the dcache is granted, unless starve_cnt == STARVE_LIMIT; in that case the icache is granted.
- The granted requester's command, addr and data drive the memory port. For an icache grant, proc2mem_data = 0.
- With no grant: proc2mem_command = NONE, addr = 0, data = 0.
- The granted requester's response = mem2proc_response. The other requester's response = 0, and it retries next cycle with its request held.

Starvation counter (starve_cnt):
- Increments when the icache is active and not granted, or is granted but mem2proc_response == 0.
- Resets to 0 when the icache is accepted (response != 0) or the icache is inactive.
- Saturates at STARVE_LIMIT.

Owner table (2^TAG_W entries, each {valid, owner}):
- Set: on a posedge where a LOAD is granted and mem2proc_response != 0, set entry[response] = {1, requester}.
- No entry for stores: stores return no data.

Return routing (combinational):
- If mem2proc_tag != 0 and entry[tag].valid, drive the owner's data/tag outputs with mem2proc_data/mem2proc_tag.
- The non-owner's tag output = 0 and its data output = 0.
- The entry is cleared at the next posedge.
- If the tag is nonzero but the entry is invalid, both tag outputs = 0 and stray_tag = 1 for that cycle.

Simultaneous events and boundaries:
- Return of tag T and a new accept of tag T in the same cycle: clear-then-set, so the entry ends valid with the new owner.
- Tag 0 is never written into the table.

Reset:
- Clears all table valid bits and starve_cnt.
- While reset is high, the memory command output is NONE. All responses, tag outputs, data outputs and stray_tag are 0.
- Loads in flight at reset are forgotten; their later returns raise stray_tag.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds 32-bit outputs icache_grants, dcache_grants and conflict_cycles.
  - icache_grants / dcache_grants count accepted requests per requester.
  - conflict_cycles counts cycles where both requesters were active.
  - All three clear on reset and wrap on overflow.
- When undefined, the ports and logic are absent and the behaviour above is unchanged.

Test Plan:
- Dcache LOAD 0x100 alone, memory accepts tag 3; tag 3 returns data 0xDEAD_BEEF 5 cycles later -> Dmem2proc_response=3, then Dmem2proc_tag=3 / data=0xDEADBEEF, Imem2proc_tag=0.
- Both caches LOAD every cycle (icache 0x40, dcache 0x80), memory always accepts -> dcache granted 4 cycles, icache granted on the 5th, pattern repeats; starve_cnt never exceeds 4.
- Icache LOAD accepted as tag 5, then dcache STORE 0x200 data 0x1234 accepted as tag 6 -> table holds only tag 5 (icache); return of tag 5 routes to icache only.
- Memory returns tag 7 with no outstanding load -> stray_tag=1 for one cycle, both cache tag outputs 0.
- Same cycle: tag 2 returns to the icache while a new dcache LOAD is accepted as tag 2 -> icache receives the data; a later return of tag 2 goes to the dcache.
- Assert reset with tags 1 and 4 outstanding, then return tag 4 -> stray_tag=1, no routing; all outputs were 0 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the tagged memory port between icache and dcache and routes returns by owner; MEM_ARB_STATS_EN adds grant/conflict counters
module mem_arbiter #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic [1:0] proc2Imem_command,
  input  logic [XLEN-1:0] proc2Imem_addr,
  output logic [TAG_W-1:0] Imem2proc_response,
  output logic [63:0] Imem2proc_data,
  output logic [TAG_W-1:0] Imem2proc_tag,
  input  logic [1:0] proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0] proc2Dmem_data,
  output logic [TAG_W-1:0] Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [TAG_W-1:0] Dmem2proc_tag,
  output logic [1:0] proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic stray_tag
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] icache_grants,
  output logic [31:0] dcache_grants,
  output logic [31:0] conflict_cycles
`endif
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;
  logic [2**TAG_W-1:0] valid, owner;
  logic i_act, d_act, gnt_i, gnt_d, accepted, hit, load_acc;
  // requests are masked during reset so every output falls to zero
  always_comb begin
    i_act = !reset && proc2Imem_command != 2'd0;
    d_act = !reset && proc2Dmem_command != 2'd0;
    gnt_d = d_act && !(i_act && starve_cnt == LIMIT);
    gnt_i = i_act && !gnt_d;
    accepted = mem2proc_response != '0;
    proc2mem_command = gnt_d ? proc2Dmem_command : gnt_i ? proc2Imem_command : 2'd0;
    proc2mem_addr = gnt_d ? proc2Dmem_addr : gnt_i ? proc2Imem_addr : '0;
    proc2mem_data = gnt_d ? proc2Dmem_data : '0;
    load_acc = accepted && proc2mem_command == 2'd1;
    Imem2proc_response = gnt_i ? mem2proc_response : '0;
    Dmem2proc_response = gnt_d ? mem2proc_response : '0;
    hit = !reset && mem2proc_tag != '0 && valid[mem2proc_tag];
    stray_tag = !reset && mem2proc_tag != '0 && !valid[mem2proc_tag];
    Imem2proc_tag = (hit && !owner[mem2proc_tag]) ? mem2proc_tag : '0;
    Imem2proc_data = (hit && !owner[mem2proc_tag]) ? mem2proc_data : '0;
    Dmem2proc_tag = (hit && owner[mem2proc_tag]) ? mem2proc_tag : '0;
    Dmem2proc_data = (hit && owner[mem2proc_tag]) ? mem2proc_data : '0;
  end
  // owner table retires a returning tag before recording a new accept, so a reused tag keeps its new owner
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      owner <= '0;
      starve_cnt <= '0;
    end else begin
      if (hit) valid[mem2proc_tag] <= 1'b0;
      if (load_acc) begin
        valid[mem2proc_response] <= 1'b1;
        owner[mem2proc_response] <= gnt_d;
      end
      starve_cnt <= (!i_act || (gnt_i && accepted)) ? '0 : (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end
`ifdef MEM_ARB_STATS_EN
  // free-running wrap-around activity counters
  always_ff @(posedge clock) begin
    if (reset) begin
      icache_grants <= '0;
      dcache_grants <= '0;
      conflict_cycles <= '0;
    end else begin
      if (gnt_i && accepted) icache_grants <= icache_grants + 1'b1;
      if (gnt_d && accepted) dcache_grants <= dcache_grants + 1'b1;
      if (i_act && d_act) conflict_cycles <= conflict_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter arbitration, starvation guard and return routing
module tb_mem_arbiter;
  logic clock = 0, reset = 1;
  logic [1:0] icmd, dcmd;
  logic [31:0] iaddr, daddr;
  logic [63:0] ddata;
  logic [3:0] iresp, dresp, itag, dtag;
  logic [63:0] irdata, drdata;
  logic [1:0] mcmd;
  logic [31:0] maddr;
  logic [63:0] mdata;
  logic [3:0] mresp, mtag;
  logic [63:0] mrdata;
  logic stray;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] ig, dg, cc;
`endif
  int nvec = 0, nerr = 0;
  typedef struct {logic [3:0] tag; logic dc;} ent_t;
  ent_t sb[$];

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .proc2Imem_command(icmd), .proc2Imem_addr(iaddr),
    .Imem2proc_response(iresp), .Imem2proc_data(irdata), .Imem2proc_tag(itag),
    .proc2Dmem_command(dcmd), .proc2Dmem_addr(daddr), .proc2Dmem_data(ddata),
    .Dmem2proc_response(dresp), .Dmem2proc_data(drdata), .Dmem2proc_tag(dtag),
    .proc2mem_command(mcmd), .proc2mem_addr(maddr), .proc2mem_data(mdata),
    .mem2proc_response(mresp), .mem2proc_data(mrdata), .mem2proc_tag(mtag),
    .stray_tag(stray)
`ifdef MEM_ARB_STATS_EN
    , .icache_grants(ig), .dcache_grants(dg), .conflict_cycles(cc)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    icmd = 0; dcmd = 0; iaddr = 0; daddr = 0; ddata = 0;
    mresp = 0; mtag = 0; mrdata = 0;
  endtask

  function automatic bit sb_take(input logic [3:0] t, output logic dc);
    dc = 0;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].tag == t) begin
        dc = sb[i].dc;
        sb.delete(i);
        return 1;
      end
    return 0;
  endfunction

  task automatic test_reset();
    icmd = 1; dcmd = 1; iaddr = 32'h40; daddr = 32'h80; ddata = 64'h55;
    mresp = 4'd3; mtag = 4'd7; mrdata = 64'hAA;
    @(negedge clock);
    nvec++; if (mcmd !== 2'd0) begin nerr++; $display("FAIL reset_cmd got %0d exp 0", mcmd); end
    nvec++; if ({iresp, dresp, itag, dtag, stray} !== 17'd0) begin nerr++; $display("FAIL reset_tags got %h exp 0", {iresp, dresp, itag, dtag, stray}); end
    nvec++; if ({irdata, drdata, mdata, maddr} !== '0) begin nerr++; $display("FAIL reset_data got nonzero exp 0"); end
    tick();
    idle();
    reset = 0;
    tick();
  endtask

  task automatic test_dcache_load();
    logic dc; bit f;
    dcmd = 1; daddr = 32'h100; mresp = 4'd3;
    @(negedge clock);
    nvec++; if (mcmd !== 2'd1 || maddr !== 32'h100) begin nerr++; $display("FAIL dload_port got %0d/%h exp 1/100", mcmd, maddr); end
    nvec++; if (dresp !== 4'd3 || iresp !== 4'd0) begin nerr++; $display("FAIL dload_resp got d=%0d i=%0d exp d=3 i=0", dresp, iresp); end
    sb.push_back('{4'd3, 1'b1});
    tick();
    idle();
    repeat (4) tick();
    mtag = 4'd3; mrdata = 64'hDEADBEEF;
    f = sb_take(4'd3, dc);
    @(negedge clock);
    nvec++; if (dtag !== (f && dc ? 4'd3 : 4'd0) || drdata !== (f && dc ? 64'hDEADBEEF : 64'd0)) begin nerr++; $display("FAIL dload_ret got tag=%0d data=%h exp 3/deadbeef", dtag, drdata); end
    nvec++; if (itag !== 4'd0 || stray !== 1'b0) begin nerr++; $display("FAIL dload_ret_i got itag=%0d stray=%b exp 0/0", itag, stray); end
    tick();
    f = sb_take(4'd3, dc);
    @(negedge clock);
    nvec++; if (stray !== !f || dtag !== 4'd0) begin nerr++; $display("FAIL dload_reret got stray=%b dtag=%0d exp 1/0", stray, dtag); end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    logic igr;
    icmd = 1; dcmd = 1; iaddr = 32'h40; daddr = 32'h80; mresp = 4'd9;
    for (int k = 0; k < 15; k++) begin
      igr = (k % 5) == 4;
      @(negedge clock);
      nvec++;
      if (maddr !== (igr ? 32'h40 : 32'h80) || iresp !== (igr ? 4'd9 : 4'd0) || dresp !== (igr ? 4'd0 : 4'd9)) begin
        nerr++; $display("FAIL starve_k%0d got addr=%h i=%0d d=%0d exp icache_grant=%b", k, maddr, iresp, dresp, igr);
      end
      tick();
    end
    idle();
    reset = 1; tick(); reset = 0; tick();
  endtask

  task automatic test_store_no_entry();
    logic dc; bit f;
    icmd = 1; iaddr = 32'h300; ddata = 64'hFFFF; mresp = 4'd5;
    @(negedge clock);
    nvec++; if (iresp !== 4'd5 || mdata !== 64'd0 || maddr !== 32'h300) begin nerr++; $display("FAIL iload got resp=%0d data=%h addr=%h exp 5/0/300", iresp, mdata, maddr); end
    sb.push_back('{4'd5, 1'b0});
    tick();
    idle();
    dcmd = 2; daddr = 32'h200; ddata = 64'h1234; mresp = 4'd6;
    @(negedge clock);
    nvec++; if (mcmd !== 2'd2 || mdata !== 64'h1234 || dresp !== 4'd6) begin nerr++; $display("FAIL dstore got cmd=%0d data=%h resp=%0d exp 2/1234/6", mcmd, mdata, dresp); end
    tick();
    idle();
    mtag = 4'd6; mrdata = 64'h66;
    f = sb_take(4'd6, dc);
    @(negedge clock);
    nvec++; if (stray !== !f || itag !== 4'd0 || dtag !== 4'd0) begin nerr++; $display("FAIL store_ret got stray=%b i=%0d d=%0d exp 1/0/0", stray, itag, dtag); end
    tick();
    mtag = 4'd5; mrdata = 64'h5555;
    f = sb_take(4'd5, dc);
    @(negedge clock);
    nvec++; if (itag !== (f && !dc ? 4'd5 : 4'd0) || irdata !== (f && !dc ? 64'h5555 : 64'd0)) begin nerr++; $display("FAIL iret got tag=%0d data=%h exp 5/5555", itag, irdata); end
    nvec++; if (dtag !== 4'd0 || drdata !== 64'd0 || stray !== 1'b0) begin nerr++; $display("FAIL iret_d got dtag=%0d ddata=%h stray=%b exp 0", dtag, drdata, stray); end
    tick();
    idle();
  endtask

  task automatic test_stray();
    mtag = 4'd7; mrdata = 64'h77;
    @(negedge clock);
    nvec++; if (stray !== 1'b1 || itag !== 4'd0 || dtag !== 4'd0) begin nerr++; $display("FAIL stray got stray=%b i=%0d d=%0d exp 1/0/0", stray, itag, dtag); end
    tick();
    idle();
    @(negedge clock);
    nvec++; if (stray !== 1'b0) begin nerr++; $display("FAIL stray_pulse got %b exp 0", stray); end
    tick();
  endtask

  task automatic test_same_cycle();
    logic dc; bit f;
    icmd = 1; iaddr = 32'h44; mresp = 4'd2;
    sb.push_back('{4'd2, 1'b0});
    tick();
    idle();
    mtag = 4'd2; mrdata = 64'hA1;
    dcmd = 1; daddr = 32'h88; mresp = 4'd2;
    f = sb_take(4'd2, dc);
    @(negedge clock);
    nvec++; if (itag !== (f && !dc ? 4'd2 : 4'd0) || irdata !== 64'hA1 || dtag !== 4'd0) begin nerr++; $display("FAIL same_ret got itag=%0d idata=%h dtag=%0d exp 2/a1/0", itag, irdata, dtag); end
    nvec++; if (dresp !== 4'd2) begin nerr++; $display("FAIL same_acc got %0d exp 2", dresp); end
    sb.push_back('{4'd2, 1'b1});
    tick();
    idle();
    mtag = 4'd2; mrdata = 64'hB2;
    f = sb_take(4'd2, dc);
    @(negedge clock);
    nvec++; if (dtag !== (f && dc ? 4'd2 : 4'd0) || drdata !== 64'hB2 || itag !== 4'd0 || stray !== 1'b0) begin nerr++; $display("FAIL same_reret got dtag=%0d ddata=%h itag=%0d stray=%b exp 2/b2/0/0", dtag, drdata, itag, stray); end
    tick();
    idle();
  endtask

  task automatic test_reset_inflight();
    logic dc; bit f;
    icmd = 1; iaddr = 32'h10; mresp = 4'd1;
    sb.push_back('{4'd1, 1'b0});
    tick();
    idle();
    dcmd = 1; daddr = 32'h20; mresp = 4'd4;
    sb.push_back('{4'd4, 1'b1});
    tick();
    reset = 1; icmd = 1; mtag = 4'd1; mrdata = 64'h11;
    @(negedge clock);
    nvec++; if (mcmd !== 2'd0 || {iresp, dresp, itag, dtag, stray} !== 17'd0 || {irdata, drdata} !== '0) begin nerr++; $display("FAIL inflight_reset got cmd=%0d tags=%h exp 0", mcmd, {iresp, dresp, itag, dtag, stray}); end
    tick();
    sb.delete();
    reset = 0;
    idle();
    tick();
    mtag = 4'd4; mrdata = 64'h44;
    f = sb_take(4'd4, dc);
    @(negedge clock);
    nvec++; if (stray !== !f || dtag !== 4'd0 || itag !== 4'd0) begin nerr++; $display("FAIL inflight_ret got stray=%b d=%0d i=%0d exp 1/0/0", stray, dtag, itag); end
    tick();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_dcache_load();
    test_starvation();
    test_store_no_entry();
    test_stray();
    test_same_cycle();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
